// File: rtl/serial_deserializer.sv
// Serial receive front end: samples a framed one-bit line at mid-bit, builds a
// MSB-first word and holds it for the downstream queue until acknowledged.
module serial_deserializer #(
  parameter int BIT_PERIOD = 100,
  parameter int WIDTH      = 8
) (
  input  logic             clock1M,
  input  logic             reset,
  input  logic             data_in,
  input  logic             write_in,
  input  logic             ack_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_ready,
  output logic             status_out
);

  localparam int CW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] MID_CYCLE  = CW'(BIT_PERIOD / 2);
  localparam logic [CW-1:0] LAST_CYCLE = CW'(BIT_PERIOD - 1);
  localparam logic [BW-1:0] LAST_BIT   = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD
  } state_t;

  state_t           r_state;
  state_t           w_stateNext;
  logic [CW-1:0]    r_cycleCnt;
  logic [CW-1:0]    w_cycleCntNext;
  logic [BW-1:0]    r_bitCnt;
  logic [BW-1:0]    w_bitCntNext;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shiftNext;
  logic [WIDTH-1:0] r_dataOut;
  logic [WIDTH-1:0] w_dataOutNext;
  logic             r_dataReady;
  logic             w_dataReadyNext;
  logic             r_writePrev;

  always_ff @(posedge clock1M or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cycleCnt  <= '0;
      r_bitCnt    <= '0;
      r_shift     <= '0;
      r_dataOut   <= '0;
      r_dataReady <= 1'b0;
      r_writePrev <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_cycleCnt  <= w_cycleCntNext;
      r_bitCnt    <= w_bitCntNext;
      r_shift     <= w_shiftNext;
      r_dataOut   <= w_dataOutNext;
      r_dataReady <= w_dataReadyNext;
      r_writePrev <= write_in;
    end
  end

  always_comb begin
    w_stateNext     = r_state;
    w_cycleCntNext  = r_cycleCnt;
    w_bitCntNext    = r_bitCnt;
    w_shiftNext     = r_shift;
    w_dataOutNext   = r_dataOut;
    w_dataReadyNext = r_dataReady;
    case (r_state)
      IDLE: begin
        if (write_in && !r_writePrev) begin
          w_stateNext    = SHIFT;
          w_cycleCntNext = '0;
          w_bitCntNext   = '0;
          w_shiftNext    = '0;
        end
      end
      SHIFT: begin
        // A short frame is dropped entirely; the last good word stays visible.
        if (!write_in) begin
          w_stateNext    = IDLE;
          w_cycleCntNext = '0;
          w_bitCntNext   = '0;
          w_shiftNext    = '0;
        end else begin
          w_cycleCntNext = (r_cycleCnt == LAST_CYCLE) ? '0 : r_cycleCnt + 1'b1;
          if (r_cycleCnt == MID_CYCLE) begin
            w_shiftNext  = {r_shift[WIDTH-2:0], data_in};
            w_bitCntNext = r_bitCnt + 1'b1;
            if (r_bitCnt == LAST_BIT) begin
              w_stateNext     = HOLD;
              w_dataOutNext   = {r_shift[WIDTH-2:0], data_in};
              w_dataReadyNext = 1'b1;
            end
          end
        end
      end
      HOLD: begin
        if (ack_in) begin
          w_stateNext     = IDLE;
          w_dataReadyNext = 1'b0;
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  assign data_out   = r_dataOut;
  assign data_ready = r_dataReady;
  assign status_out = (r_state == IDLE);

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed plus randomized bench for serial_deserializer; expected outputs come
// from a frame-level model of what the line carried at each mid-bit instant.
`timescale 1ns/1ps
module tb_serial_deserializer;

  localparam int BP = 100;
  localparam int W  = 8;

  logic         clock1M;
  logic         reset;
  logic         data_in;
  logic         write_in;
  logic         ack_in;
  logic [W-1:0] data_out;
  logic         data_ready;
  logic         status_out;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] expData;
  logic         expReady;
  logic         expStatus;

  serial_deserializer #(.BIT_PERIOD(BP), .WIDTH(W)) dut (
    .clock1M   (clock1M),
    .reset     (reset),
    .data_in   (data_in),
    .write_in  (write_in),
    .ack_in    (ack_in),
    .data_out  (data_out),
    .data_ready(data_ready),
    .status_out(status_out)
  );

  initial clock1M = 1'b0;
  always #500 clock1M = ~clock1M;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".data_out"}, 32'(data_out), 32'(expData));
    checkOutput({tag, ".data_ready"}, 32'(data_ready), 32'(expReady));
    checkOutput({tag, ".status_out"}, 32'(status_out), 32'(expStatus));
  endtask

  task automatic idleCycles(input int n, input string tag);
    repeat (n) @(negedge clock1M);
    checkAll(tag);
  endtask

  // Drives one frame starting at the current falling edge. dropAt = number of
  // bits sent before write_in falls (W = complete frame); resetAt >= 0 pulls
  // reset low at that cycle; glitch puts random values on the line away from
  // the mid-bit instants; releaseNow lets the first edge double as reset release.
  task automatic applyStimulus(input logic [W-1:0] val, input int dropAt, input int resetAt,
                               input bit glitch, input bit releaseNow);
    logic [W-1:0] bits;
    logic [W-1:0] lineSeen;
    bit           accept;
    bit           stopped;
    int           idx;
    bits     = val;
    lineSeen = '0;
    accept   = expStatus;
    stopped  = 1'b0;
    write_in = 1'b1;
    data_in  = bits[W-1];
    if (releaseNow) reset = 1'b1;
    for (int c = 0; c < W * BP; c++) begin
      @(negedge clock1M);
      if (c == 0 && accept) begin
        expStatus = 1'b0;
        checkAll("frame_start");
      end
      if (c == resetAt) begin
        reset     = 1'b0;
        #10;
        expData   = '0;
        expReady  = 1'b0;
        expStatus = 1'b1;
        checkAll("async_reset");
        write_in  = 1'b0;
        stopped   = 1'b1;
        break;
      end
      if (accept && dropAt == W && c == (BP / 2 + (W - 1) * BP)) checkAll("before_ready");
      if (accept && dropAt == W && c == (BP / 2 + (W - 1) * BP + 1)) begin
        expReady = 1'b1;
        expData  = lineSeen;
        checkAll("ready_edge");
      end
      if (!accept && (c == BP * 4 || c == BP * W - 1)) checkAll("ignored_frame");
      if (dropAt < W && c == dropAt * BP) begin
        write_in = 1'b0;
        stopped  = 1'b1;
        @(negedge clock1M);
        if (accept) expStatus = 1'b1;
        checkAll("abort");
        break;
      end
      idx = W - 1 - (c / BP);
      if (glitch && (c % BP) != BP / 2) data_in = 1'($urandom_range(0, 1));
      else data_in = bits[idx];
      // The word the receiver should build is whatever the line held mid-bit.
      if ((c % BP) == BP / 2) lineSeen = {lineSeen[W-2:0], data_in};
    end
    if (!stopped) begin
      write_in = 1'b0;
      @(negedge clock1M);
      checkAll("frame_end");
    end
  endtask

  task automatic doAck(input string tag);
    ack_in = 1'b1;
    @(negedge clock1M);
    ack_in = 1'b0;
    if (expReady) begin
      expReady  = 1'b0;
      expStatus = 1'b1;
    end
    checkAll(tag);
  endtask

  initial begin
    logic [W-1:0] patterns [5];
    logic [W-1:0] rv;
    patterns[0] = 8'hCC;
    patterns[1] = 8'hF0;
    patterns[2] = 8'h0F;
    patterns[3] = 8'h00;
    patterns[4] = 8'hFF;

    reset     = 1'b0;
    write_in  = 1'b0;
    data_in   = 1'b0;
    ack_in    = 1'b0;
    expData   = '0;
    expReady  = 1'b0;
    expStatus = 1'b1;

    idleCycles(3, "reset_state");
    reset = 1'b1;
    idleCycles(200, "idle_after_reset");

    applyStimulus(8'hAA, W, -1, 1'b0, 1'b0);
    doAck("ack_AA");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(patterns[i], W, -1, 1'b0, 1'b0);
      doAck("ack_pattern");
    end

    doAck("ack_in_idle");

    applyStimulus(8'h33, 3, -1, 1'b0, 1'b0);
    idleCycles(5, "after_abort");
    applyStimulus(8'h55, W, -1, 1'b0, 1'b0);
    doAck("ack_55");

    applyStimulus(8'h3C, W, -1, 1'b0, 1'b0);
    idleCycles(2, "hold_wait");
    applyStimulus(8'hC3, W, -1, 1'b0, 1'b0);
    write_in = 1'b1;
    idleCycles(5, "hold_write_high");
    doAck("ack_3C");
    idleCycles(200, "held_high_no_edge");
    write_in = 1'b0;
    idleCycles(2, "write_low_again");

    applyStimulus(8'h77, W, BP * 4, 1'b0, 1'b0);
    write_in = 1'b1;
    data_in  = 1'b1;
    idleCycles(3, "in_reset_write_high");
    applyStimulus(8'h99, W, -1, 1'b0, 1'b1);
    doAck("ack_99");

    for (int r = 0; r < 8; r++) begin
      rv = W'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        applyStimulus(rv, int'($urandom_range(1, W - 1)), -1, 1'b1, 1'b0);
      end else begin
        applyStimulus(rv, W, -1, 1'b1, 1'b0);
        idleCycles(int'($urandom_range(1, 20)), "rand_hold");
        doAck("rand_ack");
      end
      idleCycles(int'($urandom_range(1, 10)), "rand_gap");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_deserializer.md
# serial_deserializer

- Upstream receive stage of the serial-to-queue path.
- Samples the one-bit serial line `data_in` while `write_in` frames a transfer, and assembles 8 bits MSB-first into a byte.
- Presents the byte to the downstream queue with a ready/acknowledge handshake.
- Reports on `status_out` whether it can accept a new frame; malformed (short) frames are discarded.

## Interface

- `BIT_PERIOD`, default 100: clock cycles per serial bit; must be at least 4 and even.
- `WIDTH`, default 8: bits per frame, equal to the data_out width.
- `clock1M`  input  1: system clock; all state updates on the rising edge.
- `reset`  input  1: asynchronous, active-low reset.
- `data_in`  input  1: serial data line, MSB first.
- `write_in`  input  1: frame enable; high for the whole frame.
- `ack_in`  input  1: downstream queue accepts `data_out` (sampled only while `data_ready` = 1).
- `data_out`  output  WIDTH: last completed byte.
- `data_ready`  output  1: `data_out` holds an unconsumed byte.
- `status_out`  output  1: 1 = idle and able to start a frame, 0 = receiving or holding.

## Operation

Reset (`reset` = 0, asynchronous) sets:
- `data_out` = 0, `data_ready` = 0, `status_out` = 1.
- State IDLE, bit counter 0, cycle counter 0, shift register 0.
- `write_prev` = 0, so a `write_in` already high when reset releases counts as a rising edge.

States:
- **IDLE**
  - `status_out` = 1.
  - A rising edge of `write_in` (current 1, `write_prev` 0) goes to SHIFT. The edge cycle is cycle 0: cycle counter = 0, bit counter = 0.
  - A `write_in` held high without an edge does nothing.
- **SHIFT**
  - `status_out` = 0.
  - The cycle counter increments every cycle and wraps from BIT_PERIOD-1 to 0.
  - When the cycle counter equals BIT_PERIOD/2 (mid-bit), `data_in` shifts into the LSB of the shift register and the bit counter increments.
  - On the WIDTH-th sample, the next state is HOLD, `data_out` takes the complete shifted byte, and `data_ready` goes to 1.
  - If `write_in` = 0 in any SHIFT cycle before the WIDTH-th sample: abort to IDLE, discard partial bits, leave `data_out`/`data_ready` unchanged.
- **HOLD**
  - `status_out` = 0, `data_ready` = 1, `data_out` stable.
  - `ack_in` = 1 clears `data_ready` and moves to IDLE on the next edge.
  - `write_in` edges during HOLD are ignored; that frame is lost, and upstream must check `status_out` first.

Other rules:
- `write_prev` registers `write_in` every cycle in all states.
- After returning to IDLE, a new frame needs a fresh low-to-high edge of `write_in`.
- `ack_in` outside HOLD has no effect.
- `data_out` changes only on frame completion or reset.
- Widths:
  - Cycle counter: $clog2(BIT_PERIOD) bits.
  - Bit counter: $clog2(WIDTH+1) bits.
  - No overflow past BIT_PERIOD-1 or WIDTH.

## Timing

- Frame start at cycle 0 (edge seen). Sample k (k = 0..WIDTH-1) at cycle BIT_PERIOD/2 + k·BIT_PERIOD.
- For defaults, `data_ready` and the new `data_out` are visible after the edge at cycle 751 (50 + 700 + 1), i.e. 751 µs after frame start at 1 MHz.
- `status_out` falls the cycle after the start edge and rises the cycle after `ack_in` is sampled.
- Handshake:
  - `ack_in` high at edge n → `data_ready` = 0 after edge n.
  - The earliest next frame edge is recognised at edge n+1.
- Reset mid-frame or mid-HOLD returns all outputs to reset values immediately, with no clock needed.

## Test plan

- Reset asserted with `write_in` = 0 → `data_out` = 0, `data_ready` = 0, `status_out` = 1; release reset, 200 idle cycles → no change.
- Frame 1,0,1,0,1,0,1,0 (100 cycles per bit, `write_in` high 800 cycles) → `data_ready` rises 751 cycles after the start edge with `data_out` = 8'hAA; `status_out` = 0 from cycle 1 until ack.
- `ack_in` pulse of 1 cycle while ready → `data_ready` = 0 and `status_out` = 1 one edge later; then frames 8'hCC, 8'hF0, 8'h0F, 8'h00, 8'hFF back-to-back with acks → each byte matches exactly.
- `write_in` dropped after 3 bits of 8'h33 → state back to IDLE, `data_ready` stays 0, `data_out` keeps its previous value; the following full frame 8'h55 → `data_out` = 8'h55.
- Second frame started while `data_ready` = 1 (no ack) → ignored; `data_out` keeps its first value, `status_out` stays 0.
- `reset` pulsed low at cycle 400 of a frame → outputs return to reset values asynchronously; after release, a fresh frame 8'h99 → `data_out` = 8'h99.
